imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
Boot-time controller that owns the instruction memory write port while the CPU is held idle. It accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit words. It writes them to consecutive instruction-memory word addresses from 0, then fills every remaining location with the NOP word. When the image is complete it releases the CPU through cpu_run; a new start re-arms it for reprogramming.

Parameters:
ADDR_W, 10, instruction-memory word-address width
DEPTH, 1024, number of instruction-memory words (must be <= 2**ADDR_W)
NOP_WORD, 32'hFFFF_FFFF, fill pattern for unloaded locations

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  pulse; begins a load when in IDLE, DONE or ERROR, ignored otherwise
in_valid  input  1  byte-stream valid
in_ready  output  1  byte-stream ready
in_data  input  8  stream byte
wr_en  output  1  instruction-memory write strobe, one word per cycle
wr_addr  output  ADDR_W  word address
wr_data  output  32  word data
busy  output  1  high in any state except IDLE, DONE, ERROR
cpu_run  output  1  high only in DONE; CPU fetch/PC enable
err  output  1  sticky error flag, cleared by start
words_loaded  output  16  count of stream words written in the current/last load

Behaviour:
- Interface: one clock (clk); reset is asynchronous, active-low (rst_n).
- Reset (asynchronous, any state including mid-load): state IDLE. All outputs 0: in_ready, wr_en, wr_addr, wr_data, busy, cpu_run, err, words_loaded. Byte counter and length register cleared. Memory contents are left as-is.
- A byte is transferred when in_valid && in_ready. in_ready is registered and is high only in LEN_HI, LEN_LO and DATA (and CSUM when enabled).
- States:
  - IDLE: start -> LEN_HI.
  - LEN_HI: accept byte -> len[15:8]; go LEN_LO.
  - LEN_LO: accept byte -> len[7:0]. Then: if len > DEPTH -> ERROR. If len == 0 -> FILL with wr_addr base 0. Else -> DATA.
  - DATA: bytes are packed MSB-first (first byte -> [31:24]). On the 4th byte, the next cycle gives wr_en=1, wr_addr=word index, wr_data=word, and words_loaded increments. After word len-1, go FILL (or CSUM when enabled). in_valid with in_ready=0 has no effect.
  - FILL: writes NOP_WORD, one per cycle, at addresses len..DEPTH-1; in_ready=0. After DEPTH-1 -> DONE. If len == DEPTH, FILL writes nothing and goes straight to DONE.
  - DONE: cpu_run=1. start -> LEN_HI, and cpu_run drops the next cycle.
  - ERROR: err=1, cpu_run=0, in_ready=0. start -> LEN_HI and clears err.
- start while busy: ignored; no restart and no error.
- wr_en is never high outside DATA/FILL; at most one write per cycle.
- wr_addr holds its last value and wr_data holds its last word when wr_en=0.
- Stream stall: any number of idle cycles between bytes is legal; partial-word state is held.
- Total latency from the last data byte to cpu_run=1 is (DEPTH - len) + 2 cycles.

Optional Feature:
IMEM_LOADER_CHECKSUM_EN
- With the macro: after the last data byte the block enters CSUM and accepts one byte. This byte must equal the XOR of all length and data bytes. Match -> FILL. Mismatch -> ERROR, with no FILL writes and cpu_run staying 0.
- Without the macro: there is no CSUM state, and DATA goes directly to FILL.

Decomposition:
- Shared header/package imem_pkg holds ADDR_W, DEPTH, NOP_WORD, the state encoding constants (IDLE, LEN_HI, LEN_LO, DATA, CSUM, FILL, DONE, ERROR), and the opcode/NOP constants shared with the CPU.
- One natural sub-module, imem_word_packer: it takes bytes into a 2-bit counter and shift register, and emits word_valid plus a 32-bit word.

Test Plan:
- Reset mid-DATA (after 6 bytes) -> all outputs 0 in the same cycle, state IDLE; a new start performs a clean load.
- start; stream 00 02 8C 01 03 FE AC 01 03 FF -> writes addr0=8C0103FE, addr1=AC0103FF, then NOP_WORD at 2..1023. cpu_run=1 exactly 1024 cycles after the last byte; words_loaded=2.
- start; stream 00 00 -> 1024 NOP writes at 0..1023, then cpu_run=1, words_loaded=0.
- start; stream 04 01 (len 1025) -> err=1, no writes, cpu_run=0. The next start clears err.
- Random in_valid gaps (0-5 cycles) with len 3 -> memory image identical to the no-gap run; the start pulse during DATA is ignored.
- With IMEM_LOADER_CHECKSUM_EN: stream 00 01 12 34 56 78 plus checksum 09 -> load succeeds. Checksum 00 -> ERROR, and only addr0 was written.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared instruction-memory constants and loader state encoding.
package imem_pkg;

  localparam int          IMEM_ADDR_W   = 10;
  localparam int          IMEM_DEPTH    = 1024;
  localparam logic [31:0] IMEM_NOP_WORD = 32'hFFFF_FFFF;

  // The CPU decodes an all-ones word as NOP; keep both views in one place.
  localparam logic [31:0] CPU_NOP_INSN = IMEM_NOP_WORD;
  localparam logic [5:0]  CPU_OPC_NOP  = 6'h3F;

  localparam int LEN_W = 16;

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA, CSUM, FILL, DONE, ERROR
  } state_e;

endpackage

// File: rtl/imem_word_packer.sv
// Packs an accepted byte stream MSB-first into 32-bit words.
module imem_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        byte_vld,
  input  logic [7:0]  byte_in,
  output logic        word_vld,
  output logic [31:0] word
);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] sh_q, sh_d;

  always_comb begin
    cnt_d = cnt_q;
    sh_d  = sh_q;
    if (clr) begin
      cnt_d = '0;
      sh_d  = '0;
    end else if (byte_vld) begin
      cnt_d = cnt_q + 2'd1;
      sh_d  = {sh_q[15:0], byte_in};
    end
  end

  // The fourth byte completes the word combinationally; the caller registers it.
  assign word_vld = byte_vld && (cnt_q == 2'd3);
  assign word     = {sh_q, byte_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sh_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      sh_q  <= sh_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader owning the imem write port: length header, big-endian words, NOP fill.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader
  import imem_pkg::*;
#(
  parameter int          ADDR_W   = IMEM_ADDR_W,
  parameter int          DEPTH    = IMEM_DEPTH,
  parameter logic [31:0] NOP_WORD = IMEM_NOP_WORD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              cpu_run,
  output logic              err,
  output logic [15:0]       words_loaded
);

  state_e              state_q, state_d;
  logic                in_ready_q, in_ready_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [31:0]         wr_data_q, wr_data_d;
  logic                err_q, err_d;
  logic [LEN_W-1:0]    wl_q, wl_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W:0]      fill_q, fill_d;
  logic                fire, clr, word_vld;
  logic [31:0]         word;

  assign fire = in_valid && in_ready_q;

  imem_word_packer u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .byte_vld (fire && (state_q == DATA)),
    .byte_in  (in_data),
    .word_vld (word_vld),
    .word     (word)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (clr)                            csum_d = '0;
    else if (fire && state_q != CSUM)   csum_d = csum_q ^ in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) csum_q <= '0;
    else        csum_q <= csum_d;
  end
`endif

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    fill_d    = fill_q;
    err_d     = err_q;
    wl_d      = wl_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    clr       = 1'b0;
    case (state_q)
      IDLE, DONE, ERROR: if (start) begin
        state_d = LEN_HI;
        err_d   = 1'b0;
        len_d   = '0;
        wl_d    = '0;
        clr     = 1'b1;
      end
      LEN_HI: if (fire) begin
        len_d[15:8] = in_data;
        state_d     = LEN_LO;
      end
      LEN_LO: if (fire) begin
        len_d[7:0] = in_data;
        fill_d     = {1'b0, len_d};
        if ({1'b0, len_d} > (LEN_W+1)'(DEPTH)) begin
          state_d = ERROR;
          err_d   = 1'b1;
        end else if (len_d == '0) begin
          state_d = FILL;
        end else begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (word_vld) begin
          wr_en_d   = 1'b1;
          wr_addr_d = wl_q[ADDR_W-1:0];
          wr_data_d = word;
          wl_d      = wl_q + 16'd1;
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (word_vld && wl_d == len_q) state_d = CSUM;
`else
        // Leave only once the last word's strobe has gone out.
        if (!word_vld && wl_q == len_q) state_d = FILL;
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM: if (fire) begin
        if (in_data == csum_q) begin
          state_d = FILL;
        end else begin
          state_d = ERROR;
          err_d   = 1'b1;
        end
      end
`endif
      FILL: begin
        if (fill_q == (LEN_W+1)'(DEPTH)) begin
          state_d = DONE;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = fill_q[ADDR_W-1:0];
          wr_data_d = NOP_WORD;
          fill_d    = fill_q + 17'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == LEN_HI) || (state_d == LEN_LO) ||
                 ((state_d == DATA) && (wl_d != len_d));
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (state_d == CSUM) in_ready_d = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      err_q      <= 1'b0;
      wl_q       <= '0;
      len_q      <= '0;
      fill_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      err_q      <= err_d;
      wl_q       <= wl_d;
      len_q      <= len_d;
      fill_q     <= fill_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign err          = err_q;
  assign words_loaded = wl_q;
  assign cpu_run      = (state_q == DONE);
  assign busy         = !((state_q == IDLE) || (state_q == DONE) || (state_q == ERROR));

endmodule

// File: tb/tb_imem_loader.sv
// Directed table-driven bench for imem_loader with a write-capturing memory model.
module tb_imem_loader;

  localparam int          AW   = 10;
  localparam int          DEP  = 1024;
  localparam logic [31:0] NOP  = 32'hFFFF_FFFF;
  localparam logic [31:0] SENT = 32'hDEAD_BEEF;

  logic          clk, rst_n, start, in_valid, in_ready;
  logic [7:0]    in_data;
  logic          wr_en, busy, cpu_run, err;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic [15:0]   words_loaded;

  imem_loader #(.ADDR_W(AW), .DEPTH(DEP), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .cpu_run(cpu_run), .err(err),
    .words_loaded(words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int wr_cnt = 0;
  logic [31:0] mem [DEP];
  logic [7:0]  q [$];

  always @(posedge clk) cyc++;

  always @(negedge clk)
    if (wr_en === 1'b1) begin
      mem[wr_addr] = wr_data;
      wr_cnt++;
    end

  typedef struct {
    logic [0:13][7:0] b;
    int               n;
    bit               len_bad;
    bit               exp_err;
    logic [7:0]       csum_flip;
    int               exp_wl;
    int               exp_wr;
    logic [31:0]      w0, w1, w2;
    int               exp_lat;
  } vec_t;

  vec_t vec [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_timeout", 32'(n), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic load_q(input vec_t v);
    q.delete();
    for (int i = 0; i < v.n; i++) q.push_back(v.b[i]);
  endtask

  task automatic run_load(input string tag, input vec_t v, input int maxgap, input bit mid_start);
    logic [7:0] x = 8'h00;
    int c0, n, bad;
    for (int a = 0; a < DEP; a++) mem[a] = SENT;
    wr_cnt = 0;
    pulse_start();
    chk({tag, "_start_state"}, {29'd0, busy, err, cpu_run}, 32'b100);
    for (int i = 0; i < q.size(); i++) begin
      if (maxgap > 0) repeat ($urandom_range(maxgap, 0)) @(negedge clk);
      send(q[i]);
      x ^= q[i];
      if (mid_start && i == 6) begin
        pulse_start();
        chk({tag, "_busy_after_midstart"}, {31'd0, busy}, 32'd1);
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (!v.len_bad) send(x ^ v.csum_flip);
`endif
    c0 = cyc;
    n = 0;
    while (!cpu_run && !err && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk({tag, "_done_timeout"}, 32'(n), 32'd0);
    #1;
`ifndef IMEM_LOADER_CHECKSUM_EN
    if (v.exp_lat > 0) chk({tag, "_latency"}, 32'(cyc - c0), 32'(v.exp_lat));
`endif
    chk({tag, "_err"}, {31'd0, err}, {31'd0, v.exp_err});
    chk({tag, "_cpu_run"}, {31'd0, cpu_run}, {31'd0, !v.exp_err});
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_words_loaded"}, {16'd0, words_loaded}, 32'(v.exp_wl));
    chk({tag, "_write_count"}, 32'(wr_cnt), 32'(v.exp_wr));
    chk({tag, "_mem0"}, mem[0], v.w0);
    chk({tag, "_mem1"}, mem[1], v.w1);
    chk({tag, "_mem2"}, mem[2], v.w2);
    if (!v.exp_err) begin
      bad = 0;
      for (int a = v.exp_wl; a < DEP; a++) if (mem[a] !== NOP) bad++;
      chk({tag, "_nop_fill_bad_words"}, 32'(bad), 32'd0);
      repeat (3) @(negedge clk);
      chk({tag, "_hold"}, {cpu_run, 31'(wr_cnt)}, {1'b1, 31'(v.exp_wr)});
    end
  endtask

  initial begin
    vec_t vd;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;

    vec[0] = '{b: {8'h00,8'h02,8'h8C,8'h01,8'h03,8'hFE,8'hAC,8'h01,8'h03,8'hFF,32'h0},
               n: 10, len_bad: 0, exp_err: 0, csum_flip: 8'h00, exp_wl: 2, exp_wr: 1024,
               w0: 32'h8C0103FE, w1: 32'hAC0103FF, w2: NOP, exp_lat: 1024};
    vec[1] = '{b: {8'h04,8'h01,96'h0},
               n: 2, len_bad: 1, exp_err: 1, csum_flip: 8'h00, exp_wl: 0, exp_wr: 0,
               w0: SENT, w1: SENT, w2: SENT, exp_lat: 0};
    vec[2] = '{b: {8'h00,8'h00,96'h0},
               n: 2, len_bad: 0, exp_err: 0, csum_flip: 8'h00, exp_wl: 0, exp_wr: 1024,
               w0: NOP, w1: NOP, w2: NOP, exp_lat: 0};
    vec[3] = '{b: {8'h00,8'h03,8'h01,8'h02,8'h03,8'h04,8'hA5,8'h5A,8'h0F,8'hF0,
                   8'h10,8'h20,8'h30,8'h40},
               n: 14, len_bad: 0, exp_err: 0, csum_flip: 8'h00, exp_wl: 3, exp_wr: 1024,
               w0: 32'h01020304, w1: 32'hA55A0FF0, w2: 32'h10203040, exp_lat: 1023};

    repeat (2) @(negedge clk);
    chk("reset_ctrl", {27'd0, in_ready, wr_en, busy, cpu_run, err}, 32'd0);
    chk("reset_addr_data", {22'd0, wr_addr} | wr_data, 32'd0);
    chk("reset_words_loaded", {16'd0, words_loaded}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset while a word write is on the port, six bytes into a load.
    pulse_start();
    load_q(vec[0]);
    for (int i = 0; i < 6; i++) send(q[i]);
    chk("middata_wr_en_before_reset", {31'd0, wr_en}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("middata_reset_ctrl", {27'd0, in_ready, wr_en, busy, cpu_run, err}, 32'd0);
    chk("middata_reset_addr_data", {22'd0, wr_addr} | wr_data, 32'd0);
    chk("middata_reset_words_loaded", {16'd0, words_loaded}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 4; k++) begin
      load_q(vec[k]);
      run_load($sformatf("vec%0d", k), vec[k], 0, 1'b0);
    end

    // Same len-3 image with random stalls and a start pulse inside DATA.
    load_q(vec[3]);
    run_load("gaps", vec[3], 5, 1'b1);

    // Full-depth image: no fill writes at all.
    vd = vec[3];
    vd.exp_wl = DEP; vd.exp_wr = DEP; vd.exp_lat = 2;
    vd.w0 = 32'd0; vd.w1 = 32'd1; vd.w2 = 32'd2;
    q.delete();
    q.push_back(8'h04); q.push_back(8'h00);
    for (int i = 0; i < DEP; i++) begin
      logic [15:0] iw;
      iw = 16'(i);
      q.push_back(8'h00); q.push_back(8'h00); q.push_back(iw[15:8]); q.push_back(iw[7:0]);
    end
    run_load("full_depth", vd, 0, 1'b0);
    chk("full_depth_last_word", mem[DEP-1], 32'(DEP-1));

`ifdef IMEM_LOADER_CHECKSUM_EN
    vd = '{b: {8'h00,8'h01,8'h12,8'h34,8'h56,8'h78,64'h0},
           n: 6, len_bad: 0, exp_err: 0, csum_flip: 8'h00, exp_wl: 1, exp_wr: 1024,
           w0: 32'h12345678, w1: NOP, w2: NOP, exp_lat: 0};
    load_q(vd);
    run_load("csum_ok", vd, 0, 1'b0);
    vd.csum_flip = 8'h09; vd.exp_err = 1; vd.exp_wr = 1; vd.w1 = SENT; vd.w2 = SENT;
    load_q(vd);
    run_load("csum_bad", vd, 0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
